z_queue: RTL
============

Z_QUEUE -- requirements
Module: z_queue

Interface
REQ-001 The block SHALL expose these parameters: WIDTH, default 32, data width in bits; DEPTH, default 4, entry count (power of two, >=2).
REQ-002 The block SHALL expose these ports:
- clk  input  1  single clock; all state updates occur on the falling edge.
- rst  input  1  reset; synchronous and active-high, sampled on the falling edge of clk.
- z_in  input  1  push request.
- z_pop  input  1  pop request.
- z_flush  input  1  discard all entries.
- z_out  input  1  output enable for z_rdata.
- z_wdata  input  WIDTH  push data.
- z_rdata  output  WIDTH  head entry when z_out=1, else all zeros.
- z_count  output  $clog2(DEPTH)+1  occupied entries.
- z_full  output  1  z_count==DEPTH.
- z_empty  output  1  z_count==0.
- z_ovf  output  1  sticky flag: a push was dropped.
- z_unf  output  1  sticky flag: a pop was ignored.

Function
REQ-003 The block SHALL hold a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-004 z_rdata SHALL be combinational: z_out ? mem[head] : 0. When empty with z_out=1, it SHALL drive the last-written value at head (zero after reset); z_out SHALL NOT change any state.
REQ-005 A push with z_count<DEPTH SHALL write z_wdata to mem[tail], advance tail and increment z_count at the falling edge; data SHALL be visible on z_rdata (if head) immediately after that edge.
REQ-006 A pop with z_count>0 SHALL advance head and decrement z_count at the falling edge.
REQ-007 Push while full without a pop SHALL drop the data, leave all pointers and memory unchanged, and set z_ovf.
REQ-008 Pop while empty SHALL be ignored and SHALL set z_unf; a simultaneous push SHALL still succeed (count 0->1).
REQ-009 Simultaneous push and pop with 0<z_count<DEPTH SHALL advance both pointers and leave z_count unchanged.
REQ-010 Simultaneous push and pop when full SHALL succeed for both, with z_count staying DEPTH and no z_ovf.
REQ-011 z_flush SHALL set head=tail=0 and z_count=0 at the edge, override push and pop in the same cycle, and leave memory contents, z_ovf and z_unf unchanged.
REQ-012 z_ovf and z_unf SHALL remain set until rst; setting a flag SHALL NOT affect other operations in that cycle.
REQ-013 z_full and z_empty SHALL be combinational decodes of z_count.

Reset
REQ-014 On a falling edge with rst=1, the block SHALL clear head, tail, z_count, z_ovf and z_unf and all memory entries to 0; rst SHALL override flush, push and pop.
REQ-015 After reset the outputs SHALL be z_empty=1, z_full=0, z_count=0, and z_rdata=0 regardless of z_out.
REQ-016 rst asserted between edges SHALL have no effect until the next falling edge, since reset is synchronous.

Verification
REQ-017 Push 0x11, 0x22, 0x33 with z_out=1 -> z_rdata=0x11 and z_count=3; three pops -> z_rdata shows 0x22, then 0x33, then z_empty=1.
REQ-018 With DEPTH=4, push 5 values 0xA0..0xA4 -> z_full=1, z_ovf=1, z_count=4; pops return 0xA0..0xA3, and 0xA4 is never output.
REQ-019 Pop when empty together with a push of 0x55 -> z_unf=1, z_count=1, z_rdata=0x55.
REQ-020 When full, push 0x99 and pop in the same cycle -> z_count=4, z_ovf=0, head advanced; after 3 more pops z_rdata=0x99 (checks tail wrap-around).
REQ-021 Load 2 entries, then assert z_flush with push=1 -> z_count=0 and the push is discarded; z_out=0 at any time -> z_rdata=0.
REQ-022 Hold rst=1 during a push -> after the edge z_count=0, flags=0, z_rdata=0; with WIDTH=8, push 0xFF -> z_rdata=0xFF.

Source files
------------

// File: rtl/z_queue.sv
// rtl/z_queue.sv - circular command queue with sticky overflow/underflow flags
// All state advances on the falling edge of clk; read data is a combinational view of the head slot.
module z_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     z_in,
  input  logic                     z_pop,
  input  logic                     z_flush,
  input  logic                     z_out,
  input  logic [WIDTH-1:0]         z_wdata,
  output logic [WIDTH-1:0]         z_rdata,
  output logic [$clog2(DEPTH):0]   z_count,
  output logic                     z_full,
  output logic                     z_empty,
  output logic                     z_ovf,
  output logic                     z_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty, do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    // A pop in the same cycle frees the head slot, so a full queue can still accept the push.
    do_push = z_in && (!full || z_pop);
    do_pop  = z_pop && !empty;

    if (z_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (z_in && full && !z_pop) ovf_d = 1'b1;
      if (z_pop && empty)         unf_d = 1'b1;
      if (do_push) begin
        mem_d[tail_q] = z_wdata;
        tail_d        = tail_q + AW'(1);
      end
      if (do_pop) head_d = head_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign z_rdata = z_out ? mem_q[head_q] : '0;
  assign z_count = count_q;
  assign z_full  = full;
  assign z_empty = empty;
  assign z_ovf   = ovf_q;
  assign z_unf   = unf_q;

endmodule
